// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared constants and the entry record carried across the EX->MEM boundary.
package ex_mem_skid_reg_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 3;

  localparam int CTRL_RW  = 2;
  localparam int CTRL_M2R = 1;
  localparam int CTRL_MW  = 0;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [RW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic [DW-1:0] result;
  } entry_t;

  function automatic logic is_zero(input logic [DW-1:0] v);
    return (v == {DW{1'b0}});
  endfunction
endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// Valid/ready channel carrying one entry_t; used for both the EX and MEM sides.
interface ex_mem_skid_reg_if;
  import ex_mem_skid_reg_pkg::*;

  logic   valid;
  logic   ready;
  entry_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/ex_mem_skid_reg_chk.sv
// Occupancy invariant: the skid slot is never occupied while the head is empty.
module ex_mem_skid_reg_chk (
  input logic clk,
  input logic rst_n,
  input logic head_v_i,
  input logic skid_v_i
);
  a_no_skid_only: assert property (@(posedge clk) disable iff (!rst_n) !(skid_v_i && !head_v_i));
endmodule

// File: rtl/ex_mem_skid_reg_slot.sv
// One pipeline slot: valid bit, entry payload and its precomputed zero flag.
module ex_mem_skid_reg_slot
  import ex_mem_skid_reg_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr_i,
  input  logic   ld_i,
  input  entry_t d_i,
  input  logic   zero_i,
  output logic   valid_o,
  output entry_t q_o,
  output logic   zero_o
);
  logic   valid_q;
  entry_t data_q;
  logic   zero_q;

  // Load wins over clear; the owner never asserts both for a kill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
      zero_q  <= zero_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;
  assign zero_o  = zero_q;
endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM two-entry skid register with registered ready, zero flag and forwarding lookup.
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  ex_mem_skid_reg_if.slave      ex_if,
  ex_mem_skid_reg_if.master     mem_if,
  output logic                  mem_zero_o,
  input  logic [RW-1:0]         fwd_src_i,
  output logic                  fwd_hit_o,
  output logic [DW-1:0]         fwd_data_o,
  output logic                  fwd_load_haz_o
);
  logic   head_v, skid_v, head_z, skid_z;
  entry_t head_q, skid_q, head_d;
  logic   head_ld, head_clr, skid_ld, skid_clr, head_zd;
  logic   ex_ready_q, ex_ready_d, skid_v_d;
  logic   accept, pop, new_z;
  logic   m_head, m_skid;
  entry_t win;

  assign accept = ex_if.valid & ex_ready_q;
  assign pop    = head_v & mem_if.ready;
  assign new_z  = is_zero(ex_if.payload.result);

  // Slot steering: the skid entry refills the head before any new entry.
  always_comb begin
    head_ld  = 1'b0;
    head_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    head_d   = ex_if.payload;
    head_zd  = new_z;
    if (flush_i) begin
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!head_v || pop) begin
      if (skid_v) begin
        head_ld  = 1'b1;
        head_d   = skid_q;
        head_zd  = skid_z;
        skid_ld  = accept;
        skid_clr = !accept;
      end else begin
        head_ld  = accept;
        head_clr = !accept;
      end
    end else begin
      skid_ld = accept;
    end
  end

  assign skid_v_d   = skid_ld | (skid_v & !skid_clr);
  assign ex_ready_d = !skid_v_d;

  // Ready is a flop so no path exists from mem_ready to ex_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ready_q <= 1'b1;
    end else begin
      ex_ready_q <= ex_ready_d;
    end
  end

  ex_mem_skid_reg_slot u_head (
    .clk(clk), .rst_n(rst_n), .clr_i(head_clr), .ld_i(head_ld), .d_i(head_d),
    .zero_i(head_zd), .valid_o(head_v), .q_o(head_q), .zero_o(head_z)
  );

  ex_mem_skid_reg_slot u_skid (
    .clk(clk), .rst_n(rst_n), .clr_i(skid_clr), .ld_i(skid_ld), .d_i(ex_if.payload),
    .zero_i(new_z), .valid_o(skid_v), .q_o(skid_q), .zero_o(skid_z)
  );

  ex_mem_skid_reg_chk u_chk (
    .clk(clk), .rst_n(rst_n), .head_v_i(head_v), .skid_v_i(skid_v)
  );

  assign ex_if.ready    = ex_ready_q;
  assign mem_if.valid   = head_v;
  assign mem_if.payload = head_q;
  assign mem_zero_o     = head_z;

  assign m_head = head_v & head_q.ctrl[CTRL_RW] & (head_q.wreg == fwd_src_i) & (fwd_src_i != {RW{1'b0}});
  assign m_skid = skid_v & skid_q.ctrl[CTRL_RW] & (skid_q.wreg == fwd_src_i) & (fwd_src_i != {RW{1'b0}});

  // The skid entry is younger, so its match takes precedence.
  always_comb begin
    win            = m_skid ? skid_q : head_q;
    fwd_hit_o      = 1'b0;
    fwd_data_o     = {DW{1'b0}};
    fwd_load_haz_o = 1'b0;
    if (m_skid || m_head) begin
      fwd_hit_o      = !win.ctrl[CTRL_M2R];
      fwd_load_haz_o = win.ctrl[CTRL_M2R];
      fwd_data_o     = win.ctrl[CTRL_M2R] ? {DW{1'b0}} : win.result;
    end else begin
      fwd_hit_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed plus random bench for ex_mem_skid_reg against a queue-based FIFO model.
module tb_ex_mem_skid_reg;
  import ex_mem_skid_reg_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            mem_zero;
  logic [RW-1:0]   fwd_src;
  logic            fwd_hit;
  logic [DW-1:0]   fwd_data;
  logic            fwd_load_haz;

  ex_mem_skid_reg_if ex_if();
  ex_mem_skid_reg_if mem_if();

  ex_mem_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .ex_if(ex_if), .mem_if(mem_if),
    .mem_zero_o(mem_zero), .fwd_src_i(fwd_src), .fwd_hit_o(fwd_hit),
    .fwd_data_o(fwd_data), .fwd_load_haz_o(fwd_load_haz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     pass_cnt = 0;
  int     chk_cnt  = 0;
  entry_t mq[$];
  logic   m_ready;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic entry_t mk(input logic [2:0] c, input logic [RW-1:0] w,
                                input logic [DW-1:0] r, input logic [DW-1:0] d);
    entry_t e;
    e.ctrl = c; e.wreg = w; e.result = r; e.wdata = d;
    return e;
  endfunction

  task automatic compare_all();
    logic          e_hit, e_haz, found;
    logic [DW-1:0] e_data;
    e_hit = 1'b0; e_haz = 1'b0; e_data = '0; found = 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!found && fwd_src != 0 && mq[i].ctrl[2] && mq[i].wreg == fwd_src) begin
        found = 1'b1;
        e_haz = mq[i].ctrl[1];
        e_hit = !mq[i].ctrl[1];
        e_data = mq[i].ctrl[1] ? '0 : mq[i].result;
      end
    end
    chk("ex_ready", ex_if.ready, m_ready);
    chk("mem_valid", mem_if.valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("mem_payload", mem_if.payload, mq[0]);
      chk("mem_zero", mem_zero, mq[0].result == 0);
    end
    chk("fwd_hit", fwd_hit, e_hit);
    chk("fwd_data", fwd_data, e_data);
    chk("fwd_load_haz", fwd_load_haz, e_haz);
  endtask

  task automatic cyc(input logic v, input entry_t e, input logic mr, input logic fl,
                     input logic [RW-1:0] src);
    logic acc, pp;
    ex_if.valid = v; ex_if.payload = e; mem_if.ready = mr; flush = fl; fwd_src = src;
    #1;
    compare_all();
    acc = v && m_ready;
    pp  = (mq.size() > 0) && mr;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    m_ready = mq.size() < 2;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; ex_if.valid = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clk);
    mq.delete();
    m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  entry_t nil;

  initial begin
    nil = mk(3'b000, 5'd0, 32'h0, 32'h0);
    rst_n = 1'b0; flush = 1'b0; fwd_src = '0;
    ex_if.valid = 1'b0; ex_if.payload = nil; mem_if.ready = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);

    // Reset
    do_reset(2);
    fwd_src = 5'd3; #1;
    chk("rst_ex_ready", ex_if.ready, 1'b1);
    chk("rst_mem_valid", mem_if.valid, 1'b0);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    chk("rst_mem_zero", mem_zero, 1'b0);

    // Streaming
    for (int i = 0; i < 8; i++)
      cyc(1'b1, mk(3'b100, 5'(i + 1), 32'(i * 16 + 1), 32'(i)), 1'b1, 1'b0, 5'(i));
    chk("stream_last_valid", mem_if.valid, 1'b1);
    chk("stream_last_result", mem_if.payload.result, 32'd113);
    cyc(1'b0, nil, 1'b1, 1'b0, 5'd0);

    // Stall
    cyc(1'b1, mk(3'b100, 5'd1, 32'h10, 32'h0), 1'b0, 1'b0, 5'd0);
    cyc(1'b1, mk(3'b100, 5'd2, 32'h20, 32'h0), 1'b0, 1'b0, 5'd0);
    chk("stall_ready", ex_if.ready, 1'b0);
    chk("stall_head", mem_if.payload.result, 32'h10);
    cyc(1'b1, nil, 1'b0, 1'b0, 5'd0);
    chk("stall_hold", mem_if.payload.result, 32'h10);
    cyc(1'b0, nil, 1'b1, 1'b0, 5'd0);
    chk("stall_second", mem_if.payload.result, 32'h20);
    chk("stall_ready_back", ex_if.ready, 1'b1);
    cyc(1'b0, nil, 1'b1, 1'b0, 5'd0);

    // Flush from FULL and from ONE with a same-cycle accept
    cyc(1'b1, mk(3'b100, 5'd3, 32'h30, 32'h0), 1'b0, 1'b0, 5'd0);
    cyc(1'b1, mk(3'b100, 5'd4, 32'h40, 32'h0), 1'b0, 1'b0, 5'd0);
    cyc(1'b1, mk(3'b100, 5'd5, 32'h50, 32'h0), 1'b1, 1'b1, 5'd0);
    chk("flush_valid", mem_if.valid, 1'b0);
    chk("flush_ready", ex_if.ready, 1'b1);
    cyc(1'b1, mk(3'b100, 5'd6, 32'h60, 32'h0), 1'b0, 1'b0, 5'd0);
    cyc(1'b1, mk(3'b100, 5'd7, 32'h70, 32'h0), 1'b1, 1'b1, 5'd0);
    chk("flush_one_drop", mem_if.valid, 1'b0);
    cyc(1'b0, nil, 1'b0, 1'b0, 5'd0);

    // Forwarding: younger skid entry wins
    cyc(1'b1, mk(3'b100, 5'd5, 32'h11, 32'h0), 1'b0, 1'b0, 5'd0);
    cyc(1'b1, mk(3'b100, 5'd5, 32'h22, 32'h0), 1'b0, 1'b0, 5'd0);
    fwd_src = 5'd5; #1;
    chk("fwd_skid_wins_hit", fwd_hit, 1'b1);
    chk("fwd_skid_wins_data", fwd_data, 32'h22);
    fwd_src = 5'd0; #1;
    chk("fwd_src0_hit", fwd_hit, 1'b0);
    chk("fwd_src0_data", fwd_data, 32'h0);
    cyc(1'b0, nil, 1'b0, 1'b1, 5'd0);

    // Load hazard and zero flag
    cyc(1'b1, mk(3'b100, 5'd7, 32'h0, 32'h0), 1'b0, 1'b0, 5'd0);
    cyc(1'b1, mk(3'b110, 5'd7, 32'h99, 32'h0), 1'b0, 1'b0, 5'd0);
    fwd_src = 5'd7; #1;
    chk("load_haz", fwd_load_haz, 1'b1);
    chk("load_hit", fwd_hit, 1'b0);
    chk("head_zero", mem_zero, 1'b1);

    // Reset mid-stall drops both entries
    do_reset(1);
    chk("rst_stall_valid", mem_if.valid, 1'b0);
    chk("rst_stall_ready", ex_if.ready, 1'b1);

    // Random
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] r;
      r = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      cyc(($urandom_range(3) != 0),
          mk(3'($urandom_range(7)), 5'($urandom_range(7)), r, $urandom),
          ($urandom_range(2) != 0), ($urandom_range(15) == 0),
          5'($urandom_range(7)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
